fb_fill_controller: RTL and testbench
=====================================

FB_FILL_CONTROLLER -- requirements
Module: fb_fill_controller

Interface
REQ-001 SHALL have parameters FB_WIDTH default 800, frame-buffer pixels per row.
REQ-002 SHALL have parameter FB_HEIGHT default 600, rows per frame.
REQ-003 SHALL have parameter FB_ADDR_W default 19, frame-buffer address width.
REQ-004 SHALL have parameter FB_DATA_W default 12, pixel width {R[11:8],G[7:4],B[3:0]}.
REQ-005 SHALL have one clock and an asynchronous active-low reset:
- clk  in  1  system clock (clk_100 domain)
- reset_n  in  1  async active-low reset
REQ-006 SHALL have the remaining ports:
- cmd_valid  in  1  fill command present
- cmd_ready  out  1  command accepted this cycle when high with cmd_valid
- cmd_x0, cmd_y0  in  10  top-left corner, inclusive
- cmd_x1, cmd_y1  in  10  bottom-right corner, exclusive
- cmd_color  in  FB_DATA_W  fill colour
- abort  in  1  cancel the fill in progress
- fb_we  out  1  frame-buffer write enable
- fb_addr  out  FB_ADDR_W  write address
- fb_wdata  out  FB_DATA_W  write data
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on normal completion

Function
REQ-007 SHALL implement states IDLE, SETUP, FILL and DONE.
REQ-008 SHALL assert cmd_ready only in IDLE; handshake = cmd_valid&&cmd_ready at a rising edge; all cmd_* fields latched at that edge.
REQ-009 SHALL move IDLE->SETUP on handshake; the SETUP cycle clips x1c=min(x1,FB_WIDTH), y1c=min(y1,FB_HEIGHT) and computes base=y0*FB_WIDTH+x0 into a register.
REQ-010 SHALL move SETUP->DONE when x0>=x1c or y0>=y1c (empty command, zero writes); otherwise SETUP->FILL.
REQ-011 SHALL, in FILL, write exactly one pixel per cycle in raster order: fb_we=1, fb_wdata=latched colour, fb_addr=current address; fb_we, fb_addr and fb_wdata are registered outputs.
REQ-012 SHALL step addresses incrementally, with no multiplier in FILL: +1 within a row; at the row end x resets to x0 and the row base advances by FB_WIDTH.
REQ-013 SHALL, for a non-empty command accepted at edge k, assert fb_we for exactly N=(x1c-x0)*(y1c-y0) consecutive cycles starting after edge k+2, then pulse done for one cycle after edge k+2+N.
REQ-014 SHALL move DONE->IDLE after one cycle; cmd_ready is high again in the cycle following the done pulse.
REQ-015 SHALL, when abort is high in SETUP or FILL, go to IDLE at the next edge: fb_we low from that edge, no done pulse, pixels already written left unchanged.
REQ-016 SHALL ignore abort in IDLE and DONE; abort together with cmd_valid in IDLE SHALL still accept the command.
REQ-017 SHALL hold fb_addr and fb_wdata at their last values whenever fb_we is low.

Reset
REQ-018 SHALL, on reset_n low, asynchronously force state=IDLE, fb_we=0, fb_addr=0, fb_wdata=0, busy=0, done=0, cmd_ready=1 after reset release, and clear all counters.
REQ-019 SHALL, when reset is asserted mid-FILL, stop writes immediately and produce no done pulse.

Structure
REQ-020 SHALL take FB_WIDTH, FB_HEIGHT, FB_ADDR_W, FB_DATA_W and the state encoding from shared package fb_pkg.
REQ-021 SHALL place the x/y/address stepping in one sub-module, fb_raster_counter (load, step, last-pixel flag).

Verification
REQ-022 Clear: (0,0,800,600), colour 000 -> 480000 writes, addresses 0..479999 contiguous, done after edge k+480002.
REQ-023 Rectangle: (200,150,600,450), colour F00 -> 120000 writes, first address 120200, row-2 first address 121000, last address 359799, all data F00.
REQ-024 Clip: (790,590,900,700), colour 0F0 -> 100 writes, first address 472790, last address 479999.
REQ-025 Empty: (100,100,100,200) -> zero fb_we cycles, done pulses after edge k+2, cmd_ready high the cycle after.
REQ-026 Abort: rectangle (0,0,800,600); assert abort after 50 writes -> fb_we low next cycle, no done, cmd_ready high; a new command is then accepted normally.
REQ-027 Reset: reset_n low mid-FILL -> fb_we=0 asynchronously, state IDLE; back-to-back commands with cmd_valid held high -> second accepted in the cycle after the done pulse.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared frame-buffer geometry, FSM state encoding and coordinate helpers
// for the rectangle fill controller.
package fb_pkg;

    localparam int FB_WIDTH  = 800;
    localparam int FB_HEIGHT = 600;
    localparam int FB_ADDR_W = 19;
    localparam int FB_DATA_W = 12;
    localparam int COORD_W   = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_FILL  = 2'd2,
        ST_DONE  = 2'd3
    } fb_state_t;

    // Exclusive end coordinate clamped to the buffer edge; one extra bit so the
    // limit itself (e.g. 800) is representable.
    function automatic logic [COORD_W:0] clip_coord(input logic [COORD_W-1:0] coord,
                                                    input int limit);
        logic [COORD_W:0] lim;
        lim = (COORD_W+1)'(limit);
        return ({1'b0, coord} > lim) ? lim : {1'b0, coord};
    endfunction

endpackage

// File: rtl/fb_fill_controller_if.sv
// Command handshake and frame-buffer write bus shared by the fill controller
// and whatever issues commands / owns the memory.
interface fb_fill_if #(
    parameter int ADDR_W  = fb_pkg::FB_ADDR_W,
    parameter int DATA_W  = fb_pkg::FB_DATA_W,
    parameter int COORD_W = fb_pkg::COORD_W
);

    logic               cmd_valid;
    logic               cmd_ready;
    logic [COORD_W-1:0] cmd_x0;
    logic [COORD_W-1:0] cmd_y0;
    logic [COORD_W-1:0] cmd_x1;
    logic [COORD_W-1:0] cmd_y1;
    logic [DATA_W-1:0]  cmd_color;
    logic               fb_we;
    logic [ADDR_W-1:0]  fb_addr;
    logic [DATA_W-1:0]  fb_wdata;

    modport master (
        output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
        input  cmd_ready, fb_we, fb_addr, fb_wdata
    );

    modport slave (
        input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
        output cmd_ready, fb_we, fb_addr, fb_wdata
    );

endinterface

// File: rtl/fb_raster_counter.sv
// Raster walker over a clipped rectangle: loads a start address once, then
// advances by +1 along a row and by one row pitch at each row end.
module fb_raster_counter #(
    parameter int FB_WIDTH = fb_pkg::FB_WIDTH,
    parameter int ADDR_W   = fb_pkg::FB_ADDR_W,
    parameter int COORD_W  = fb_pkg::COORD_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic               step,
    input  logic [COORD_W-1:0] x_start,
    input  logic [COORD_W-1:0] y_start,
    input  logic [COORD_W:0]   x_end,
    input  logic [COORD_W:0]   y_end,
    input  logic [ADDR_W-1:0]  base,
    output logic [ADDR_W-1:0]  addr,
    output logic               last
);

    localparam logic [COORD_W:0]  ONE      = (COORD_W+1)'(1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_WIDTH);

    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x_first;
    logic [COORD_W:0]   x_stop;
    logic [COORD_W:0]   y_stop;
    logic [ADDR_W-1:0]  row_base;
    logic               row_end;

    assign row_end = (({1'b0, x} + ONE) == x_stop);
    assign last    = row_end && (({1'b0, y} + ONE) == y_stop);

    // Row pitch is added to a saved row base so no multiply is needed per pixel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x        <= '0;
            y        <= '0;
            x_first  <= '0;
            x_stop   <= '0;
            y_stop   <= '0;
            row_base <= '0;
            addr     <= '0;
        end else if (load) begin
            x        <= x_start;
            y        <= y_start;
            x_first  <= x_start;
            x_stop   <= x_end;
            y_stop   <= y_end;
            row_base <= base;
            addr     <= base;
        end else if (step) begin
            if (row_end) begin
                x        <= x_first;
                y        <= y + COORD_W'(1);
                row_base <= row_base + ROW_STEP;
                addr     <= row_base + ROW_STEP;
            end else begin
                x        <= x + COORD_W'(1);
                addr     <= addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/fb_fill_controller.sv
// Fills a clipped rectangle of the frame buffer with one colour, one pixel per
// clock in raster order, with abort and a completion pulse.
module fb_fill_controller #(
    parameter int FB_WIDTH  = fb_pkg::FB_WIDTH,
    parameter int FB_HEIGHT = fb_pkg::FB_HEIGHT,
    parameter int FB_ADDR_W = fb_pkg::FB_ADDR_W,
    parameter int FB_DATA_W = fb_pkg::FB_DATA_W
) (
    input  logic     clk,
    input  logic     reset_n,
    fb_fill_if.slave bus,
    input  logic     abort,
    output logic     busy,
    output logic     done
);

    import fb_pkg::*;

    fb_state_t state;
    fb_state_t state_next;

    logic [COORD_W-1:0]   x0_r;
    logic [COORD_W-1:0]   y0_r;
    logic [COORD_W-1:0]   x1_r;
    logic [COORD_W-1:0]   y1_r;
    logic [FB_DATA_W-1:0] color_r;

    logic [COORD_W:0]     x_end;
    logic [COORD_W:0]     y_end;
    logic [FB_ADDR_W-1:0] base_c;
    logic                 empty_cmd;
    logic                 handshake;

    logic [FB_ADDR_W-1:0] rc_addr;
    logic                 rc_last;
    logic                 rc_load;
    logic                 rc_step;

    logic                 fb_we_r;
    logic [FB_ADDR_W-1:0] fb_addr_r;
    logic [FB_DATA_W-1:0] fb_wdata_r;
    logic                 done_r;
    logic                 we_next;
    logic [FB_ADDR_W-1:0] addr_next;
    logic [FB_DATA_W-1:0] wdata_next;

    // Ready is held off during the done pulse so a queued command is taken one
    // cycle after completion is signalled.
    assign bus.cmd_ready = (state == ST_IDLE) && !done_r;
    assign handshake     = bus.cmd_valid && bus.cmd_ready;
    assign busy          = (state != ST_IDLE);
    assign done          = done_r;
    assign bus.fb_we     = fb_we_r;
    assign bus.fb_addr   = fb_addr_r;
    assign bus.fb_wdata  = fb_wdata_r;

    assign x_end     = clip_coord(x1_r, FB_WIDTH);
    assign y_end     = clip_coord(y1_r, FB_HEIGHT);
    assign empty_cmd = ({1'b0, x0_r} >= x_end) || ({1'b0, y0_r} >= y_end);
    assign base_c    = FB_ADDR_W'(y0_r) * FB_ADDR_W'(FB_WIDTH) + FB_ADDR_W'(x0_r);

    fb_raster_counter #(
        .FB_WIDTH (FB_WIDTH),
        .ADDR_W   (FB_ADDR_W),
        .COORD_W  (COORD_W)
    ) u_raster (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (rc_load),
        .step     (rc_step),
        .x_start  (x0_r),
        .y_start  (y0_r),
        .x_end    (x_end),
        .y_end    (y_end),
        .base     (base_c),
        .addr     (rc_addr),
        .last     (rc_last)
    );

    always_comb begin
        state_next = state;
        we_next    = 1'b0;
        addr_next  = fb_addr_r;
        wdata_next = fb_wdata_r;
        rc_load    = 1'b0;
        rc_step    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (handshake) state_next = ST_SETUP;
            end
            ST_SETUP: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (empty_cmd) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_FILL;
                    rc_load    = 1'b1;
                end
            end
            ST_FILL: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else begin
                    we_next    = 1'b1;
                    addr_next  = rc_addr;
                    wdata_next = color_r;
                    rc_step    = 1'b1;
                    if (rc_last) state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            fb_we_r    <= 1'b0;
            fb_addr_r  <= '0;
            fb_wdata_r <= '0;
            done_r     <= 1'b0;
            x0_r       <= '0;
            y0_r       <= '0;
            x1_r       <= '0;
            y1_r       <= '0;
            color_r    <= '0;
        end else begin
            state      <= state_next;
            fb_we_r    <= we_next;
            fb_addr_r  <= addr_next;
            fb_wdata_r <= wdata_next;
            done_r     <= (state == ST_DONE);
            if (handshake) begin
                x0_r    <= bus.cmd_x0;
                y0_r    <= bus.cmd_y0;
                x1_r    <= bus.cmd_x1;
                y1_r    <= bus.cmd_y1;
                color_r <= bus.cmd_color;
            end
        end
    end

endmodule

// File: tb/tb_fb_fill_controller.sv
// Directed self-checking bench for fb_fill_controller on an 80x60 buffer so the
// full-frame and clipping cases stay short.
module tb_fb_fill_controller;

    localparam int W  = 80;
    localparam int H  = 60;
    localparam int AW = 13;
    localparam int DW = 12;
    localparam int CW = 10;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic abort = 1'b0;
    logic busy;
    logic done;

    fb_fill_if #(.ADDR_W(AW), .DATA_W(DW), .COORD_W(CW)) bus ();

    fb_fill_controller #(
        .FB_WIDTH  (W),
        .FB_HEIGHT (H),
        .FB_ADDR_W (AW),
        .FB_DATA_W (DW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .abort   (abort),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int wr_cnt = 0, bad = 0, done_cnt = 0;
    int first_cyc, last_cyc, first_addr, last_addr, row2_addr;
    int mon_x0, mon_xend, mon_ex, mon_ey, mon_color, mon_row_len;

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor with its own raster model of the expected address sequence.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (bus.fb_we) begin
            wr_cnt++;
            if (wr_cnt == 1) begin
                first_cyc  = cyc;
                first_addr = int'(bus.fb_addr);
            end
            if (wr_cnt == mon_row_len + 1) row2_addr = int'(bus.fb_addr);
            last_cyc  = cyc;
            last_addr = int'(bus.fb_addr);
            if (int'(bus.fb_addr) != mon_ey * W + mon_ex || int'(bus.fb_wdata) != mon_color) bad++;
            mon_ex++;
            if (mon_ex == mon_xend) begin
                mon_ex = mon_x0;
                mon_ey++;
            end
        end
    end

    task automatic checkOutput(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic startCommand(input int x0, input int y0, input int x1, input int y1,
                                input int color, input int xend, input bit with_abort,
                                input string tag, output int k);
        @(negedge clk);
        #1;
        wr_cnt = 0; bad = 0;
        first_cyc = -1; last_cyc = -1; first_addr = -1; last_addr = -1; row2_addr = -1;
        mon_x0 = x0; mon_ex = x0; mon_ey = y0; mon_xend = xend;
        mon_row_len = xend - x0; mon_color = color;
        bus.cmd_x0 = CW'(x0);
        bus.cmd_y0 = CW'(y0);
        bus.cmd_x1 = CW'(x1);
        bus.cmd_y1 = CW'(y1);
        bus.cmd_color = DW'(color);
        bus.cmd_valid = 1'b1;
        abort = with_abort;
        checkOutput({tag, "_ready"}, int'(bus.cmd_ready), 1);
        @(posedge clk);
        #1;
        k = cyc;
        bus.cmd_valid = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_busy_setup"}, int'(busy), 1);
        checkOutput({tag, "_ready_low"}, int'(bus.cmd_ready), 0);
    endtask

    task automatic applyStimulus(input int x0, input int y0, input int x1, input int y1,
                                 input int color, input int xend, input bit with_abort,
                                 input int exp_n, input int exp_first, input int exp_row2,
                                 input int exp_last, input string tag);
        int k;
        int dcyc;
        bit seen;
        startCommand(x0, y0, x1, y1, color, xend, with_abort, tag, k);
        seen = 1'b0;
        dcyc = -1;
        for (int j = 0; j < exp_n + 20 && !seen; j++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                dcyc = cyc;
            end
        end
        checkOutput({tag, "_done_seen"}, int'(seen), 1);
        checkOutput({tag, "_done_cycle"}, dcyc - k, 2 + exp_n);
        checkOutput({tag, "_writes"}, wr_cnt, exp_n);
        if (exp_n > 0) begin
            checkOutput({tag, "_first_cycle"}, first_cyc - k, 2);
            checkOutput({tag, "_last_cycle"}, last_cyc - k, 1 + exp_n);
            checkOutput({tag, "_first_addr"}, first_addr, exp_first);
            checkOutput({tag, "_last_addr"}, last_addr, exp_last);
            checkOutput({tag, "_bad_pixels"}, bad, 0);
        end
        if (exp_row2 >= 0) checkOutput({tag, "_row2_addr"}, row2_addr, exp_row2);
        @(negedge clk);
        checkOutput({tag, "_done_low"}, int'(done), 0);
        checkOutput({tag, "_ready_after"}, int'(bus.cmd_ready), 1);
        checkOutput({tag, "_idle_after"}, int'(busy), 0);
        checkOutput({tag, "_we_after"}, int'(bus.fb_we), 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        int d0;
        int dcyc;
        bit reached;

        bus.cmd_valid = 1'b0;
        bus.cmd_x0 = '0; bus.cmd_y0 = '0; bus.cmd_x1 = '0; bus.cmd_y1 = '0;
        bus.cmd_color = '0;
        mon_x0 = 0; mon_ex = 0; mon_ey = 0; mon_xend = 1; mon_row_len = 0; mon_color = 0;

        repeat (2) @(negedge clk);
        checkOutput("rst_we", int'(bus.fb_we), 0);
        checkOutput("rst_addr", int'(bus.fb_addr), 0);
        checkOutput("rst_wdata", int'(bus.fb_wdata), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        #1 reset_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_ready", int'(bus.cmd_ready), 1);

        applyStimulus(0, 0, 80, 60, 'h000, 80, 1'b0, 4800, 0, 80, 4799, "clear");
        applyStimulus(20, 15, 60, 45, 'hF00, 60, 1'b0, 1200, 1220, 1300, 3579, "rect");
        applyStimulus(70, 50, 90, 70, 'h0F0, 80, 1'b1, 100, 4070, 4150, 4799, "clip_abort_idle");
        applyStimulus(10, 10, 10, 20, 'hABC, 10, 1'b0, 0, -1, -1, -1, "empty_x");
        applyStimulus(5, 70, 40, 90, 'h123, 40, 1'b0, 0, -1, -1, -1, "empty_y_clip");

        // Abort after exactly 50 writes of a full-frame fill.
        startCommand(0, 0, 80, 60, 'h555, 80, 1'b0, "abort", k);
        d0 = done_cnt;
        reached = 1'b0;
        for (int j = 0; j < 200 && !reached; j++) begin
            @(negedge clk);
            #1;
            if (wr_cnt == 50) reached = 1'b1;
        end
        checkOutput("abort_reach50", int'(reached), 1);
        abort = 1'b1;
        @(negedge clk);
        checkOutput("abort_we_low", int'(bus.fb_we), 0);
        checkOutput("abort_idle", int'(busy), 0);
        checkOutput("abort_ready", int'(bus.cmd_ready), 1);
        #1 abort = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("abort_writes", wr_cnt, 50);
        checkOutput("abort_no_done", done_cnt - d0, 0);
        checkOutput("abort_addr_hold", int'(bus.fb_addr), 49);
        checkOutput("abort_data_hold", int'(bus.fb_wdata), 'h555);
        checkOutput("abort_bad_pixels", bad, 0);
        applyStimulus(2, 3, 6, 5, 'h0AF, 6, 1'b0, 8, 242, 322, 325, "after_abort");

        // Asynchronous reset in the middle of a fill.
        startCommand(0, 0, 80, 60, 'h777, 80, 1'b0, "rstfill", k);
        reached = 1'b0;
        for (int j = 0; j < 200 && !reached; j++) begin
            @(negedge clk);
            #1;
            if (wr_cnt == 20) reached = 1'b1;
        end
        checkOutput("rstfill_reach20", int'(reached), 1);
        d0 = done_cnt;
        #1 reset_n = 1'b0;
        #1;
        checkOutput("rstfill_we_async", int'(bus.fb_we), 0);
        checkOutput("rstfill_busy_async", int'(busy), 0);
        checkOutput("rstfill_addr_async", int'(bus.fb_addr), 0);
        @(negedge clk);
        #1 reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rstfill_writes", wr_cnt, 20);
        checkOutput("rstfill_no_done", done_cnt - d0, 0);
        checkOutput("rstfill_ready", int'(bus.cmd_ready), 1);

        // Back-to-back commands with cmd_valid held high throughout.
        @(negedge clk);
        #1;
        wr_cnt = 0;
        bus.cmd_x0 = CW'(2); bus.cmd_y0 = CW'(2); bus.cmd_x1 = CW'(5); bus.cmd_y1 = CW'(4);
        bus.cmd_color = DW'('h321);
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        k = cyc;
        bus.cmd_x0 = CW'(10); bus.cmd_y0 = CW'(10); bus.cmd_x1 = CW'(12); bus.cmd_y1 = CW'(11);
        bus.cmd_color = DW'('h654);
        dcyc = -1;
        for (int j = 0; j < 40 && dcyc < 0; j++) begin
            @(negedge clk);
            if (done) dcyc = cyc;
        end
        checkOutput("b2b_first_done", dcyc - k, 8);
        @(negedge clk);
        checkOutput("b2b_ready_after_done", int'(bus.cmd_ready), 1);
        checkOutput("b2b_first_writes", wr_cnt, 6);
        @(posedge clk);
        #1;
        k = cyc;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        checkOutput("b2b_second_busy", int'(busy), 1);
        dcyc = -1;
        for (int j = 0; j < 40 && dcyc < 0; j++) begin
            @(negedge clk);
            if (done) dcyc = cyc;
        end
        checkOutput("b2b_second_done", dcyc - k, 4);
        checkOutput("b2b_total_writes", wr_cnt, 8);
        checkOutput("b2b_last_addr", int'(bus.fb_addr), 10 * W + 11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
